// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep of an NI-input partition pair, accumulating mismatch, Hamming and
// absolute-error metrics. Define SWEEP_WORST_CASE_EN to build worst-case error tracking.
module partition_sweep_checker #(
  parameter int NI = 7,
  parameter int NO = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [NI-1:0]              stim,
  input  logic [NO-1:0]              exact_po,
  input  logic [NO-1:0]              approx_po,
  output logic                       busy,
  output logic                       done,
  output logic [NI:0]                vec_count,
  output logic [NI:0]                err_vectors,
  output logic [NI+$clog2(NO+1)-1:0] bit_errors,
  output logic [NI+NO-1:0]           abs_err_sum,
  output logic [NO-1:0]              worst_err,
  output logic [NI-1:0]              worst_vec
);
  localparam int PW = $clog2(NO+1);
  localparam int BW = NI + PW;
  localparam int AW = NI + NO;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_nxt;

  logic          go, step, last;
  logic [NO-1:0] xr, diff;
  logic [PW-1:0] pop;

  assign go   = start && (state == IDLE || state == DONE);
  assign step = (state == SWEEP) && !abort;
  assign last = (stim == {NI{1'b1}});
  assign busy = (state == SWEEP);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SWEEP;
      SWEEP: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Error metrics of the vector currently on stim (partitions are combinational)
  always_comb begin
    xr   = exact_po ^ approx_po;
    diff = (exact_po >= approx_po) ? exact_po - approx_po : approx_po - exact_po;
    pop  = '0;
    for (int i = 0; i < NO; i++) pop = pop + PW'(xr[i]);
  end

  // stim wraps to 0 on the final vector, so it reads 0 throughout DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stim        <= '0;
      vec_count   <= '0;
      err_vectors <= '0;
      bit_errors  <= '0;
      abs_err_sum <= '0;
    end else if (go) begin
      stim        <= '0;
      vec_count   <= '0;
      err_vectors <= '0;
      bit_errors  <= '0;
      abs_err_sum <= '0;
    end else if (step) begin
      stim        <= stim + NI'(1);
      vec_count   <= vec_count + (NI+1)'(1);
      err_vectors <= err_vectors + (NI+1)'(|xr);
      bit_errors  <= bit_errors + BW'(pop);
      abs_err_sum <= abs_err_sum + AW'(diff);
    end

`ifdef SWEEP_WORST_CASE_EN
  // Strictly-greater update keeps the earliest vector on ties
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      worst_err <= '0;
      worst_vec <= '0;
    end else if (go) begin
      worst_err <= '0;
      worst_vec <= '0;
    end else if (step && diff > worst_err) begin
      worst_err <= diff;
      worst_vec <= stim;
    end
`else
  assign worst_err = '0;
  assign worst_vec = '0;
`endif

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Randomized/directed bench for partition_sweep_checker with a sweep-history reference model.
module tb_partition_sweep_checker;
  localparam int NI = 7;
  localparam int NO = 4;
  localparam int N  = 1 << NI;

  logic                       clk, rst_n, start, abort, busy, done;
  logic [NI-1:0]              stim, worst_vec;
  logic [NO-1:0]              exact_po, approx_po, worst_err;
  logic [NI:0]                vec_count, err_vectors;
  logic [NI+$clog2(NO+1)-1:0] bit_errors;
  logic [NI+NO-1:0]           abs_err_sum;

  int n_cmp, n_bad;
  int mode;
  logic [NO-1:0] tab_e [N];
  logic [NO-1:0] tab_a [N];

  partition_sweep_checker #(.NI(NI), .NO(NO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim),
    .exact_po(exact_po), .approx_po(approx_po), .busy(busy), .done(done),
    .vec_count(vec_count), .err_vectors(err_vectors), .bit_errors(bit_errors),
    .abs_err_sum(abs_err_sum), .worst_err(worst_err), .worst_vec(worst_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partition pair under evaluation, selected by mode
  assign exact_po  = (mode == 3) ? tab_e[stim] : stim[NO-1:0];
  assign approx_po = (mode == 0) ? stim[NO-1:0] :
                     (mode == 1) ? (stim[NO-1:0] ^ 4'b0001) :
                     (mode == 2) ? 4'b0000 : tab_a[stim];

  function automatic int pe(int v);
    return (mode == 3) ? int'(tab_e[v]) : (v % 16);
  endfunction
  function automatic int pa(int v);
    case (mode)
      0:       return v % 16;
      1:       return (v % 16) ^ 1;
      2:       return 0;
      default: return int'(tab_a[v]);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: phase (0 idle, 1 sweep, 2 done), vectors accumulated, and the
  // exact/approx pair seen for every accumulated vector
  int m_ph, m_k;
  int m_ex [N];
  int m_ap [N];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ph <= 0;
      m_k  <= 0;
    end else if (m_ph == 1) begin
      if (abort) m_ph <= 0;
      else begin
        m_ex[m_k] <= pe(m_k);
        m_ap[m_k] <= pa(m_k);
        m_k <= m_k + 1;
        if (m_k == N-1) m_ph <= 2;
      end
    end else if (start) begin
      m_ph <= 1;
      m_k  <= 0;
    end

  // Every-cycle compare: outputs are sums over the recorded history
  always @(negedge clk) begin
    int ev, be, ae, we, wv, d, x;
    ev = 0; be = 0; ae = 0; we = 0; wv = 0;
    for (int v = 0; v < m_k; v++) begin
      x  = m_ex[v] ^ m_ap[v];
      d  = (m_ex[v] > m_ap[v]) ? m_ex[v] - m_ap[v] : m_ap[v] - m_ex[v];
      ev += (x != 0) ? 1 : 0;
      be += $countones(x[NO-1:0]);
      ae += d;
      if (d > we) begin we = d; wv = v; end
    end
`ifndef SWEEP_WORST_CASE_EN
    we = 0; wv = 0;
`endif
    chk("busy", int'(busy), (m_ph == 1) ? 1 : 0);
    chk("done", int'(done), (m_ph == 2) ? 1 : 0);
    chk("stim", int'(stim), m_k % N);
    chk("vec_count", int'(vec_count), m_k);
    chk("err_vectors", int'(err_vectors), ev);
    chk("bit_errors", int'(bit_errors), be);
    chk("abs_err_sum", int'(abs_err_sum), ae);
    chk("worst_err", int'(worst_err), we);
    chk("worst_vec", int'(worst_vec), wv);
  end

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, N);
  endtask

  task automatic run_sweep(input int md);
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done($sformatf("sweep_m%0d", md));
  endtask

  task automatic final_chk(input string name, input int ev, input int be, input int ae,
                           input int we, input int wv);
    chk({name, "_vec_count"}, int'(vec_count), N);
    chk({name, "_err_vectors"}, int'(err_vectors), ev);
    chk({name, "_bit_errors"}, int'(bit_errors), be);
    chk({name, "_abs_err_sum"}, int'(abs_err_sum), ae);
`ifdef SWEEP_WORST_CASE_EN
    chk({name, "_worst_err"}, int'(worst_err), we);
    chk({name, "_worst_vec"}, int'(worst_vec), wv);
`else
    chk({name, "_worst_err"}, int'(worst_err), 0);
    chk({name, "_worst_vec"}, int'(worst_vec), 0);
`endif
  endtask

  task automatic partial(input int md, input int p, input bit with_start);
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (p) @(negedge clk);
    abort = 1'b1;
    start = with_start;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_vec_count", int'(vec_count), p);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    for (int i = 0; i < N; i++) begin tab_e[i] = '0; tab_a[i] = '0; end
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vec_count", int'(vec_count), 0);
    chk("rst_abs_err_sum", int'(abs_err_sum), 0);

    run_sweep(0); final_chk("identical", 0, 0, 0, 0, 0);
    run_sweep(1); final_chk("xor1", 128, 128, 128, 1, 0);
    run_sweep(2); final_chk("zero", 120, 256, 960, 15, 15);

    // abort at stim=50 with start raised alongside: abort wins
    partial(2, 50, 1'b1);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    run_sweep(2); final_chk("zero_rerun", 120, 256, 960, 15, 15);

    // start held through a sweep and into DONE
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    wait_done("held");
    final_chk("held", 128, 128, 128, 1, 0);
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_vec_count", int'(vec_count), 0);
    wait_done("held2");

    // async reset mid-sweep at stim=77
    for (int i = 0; i < N; i++) begin tab_e[i] = NO'($urandom); tab_a[i] = NO'($urandom); end
    @(negedge clk);
    mode  = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (77) @(negedge clk);
    chk("pre_rst_stim", int'(stim), 77);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stim", int'(stim), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_vec_count", int'(vec_count), 0);
    chk("async_rst_err_vectors", int'(err_vectors), 0);
    chk("async_rst_bit_errors", int'(bit_errors), 0);
    chk("async_rst_abs_err_sum", int'(abs_err_sum), 0);
    chk("async_rst_worst", int'(worst_err) + int'(worst_vec), 0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);

    // randomized partitions, with random aborts
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin tab_e[i] = NO'($urandom); tab_a[i] = NO'($urandom); end
      if (r[0]) partial(3, int'($urandom_range(1, N-2)), 1'($urandom));
      run_sweep(3);
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/partition_sweep_checker.md
# partition_sweep_checker

Sequential sweep-and-compare engine for evaluating approximate partitions. It drives every input vector of an NI-input combinational partition in ascending order. It compares the exact and approximate partition outputs for each vector and accumulates the error metrics used for partition selection: mismatching-vector count, total Hamming distance and summed absolute error. It sits directly upstream of the partition pair (feeding `stim`) and downstream of it (consuming both `po` buses).

## Interface
- `NI`, 7, partition input width (1..16)
- `NO`, 4, partition output width (1..16)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin sweep (accepted in IDLE or DONE only)
- `abort`  in  1  cancel sweep (acts in SWEEP only)
- `stim`  out  NI  vector driven to both partitions
- `exact_po`  in  NO  exact partition output for current `stim`
- `approx_po`  in  NO  approximate partition output for current `stim`
- `busy`  out  1  high in SWEEP
- `done`  out  1  high in DONE; results valid and stable
- `vec_count`  out  NI+1  vectors evaluated
- `err_vectors`  out  NI+1  vectors with `exact_po != approx_po`
- `bit_errors`  out  NI+$clog2(NO+1)  sum of popcount(exact_po ^ approx_po)
- `abs_err_sum`  out  NI+NO  sum of |exact_po − approx_po|, both treated as unsigned
- `worst_err`  out  NO  maximum |exact_po − approx_po|
- `worst_vec`  out  NI  first vector achieving `worst_err`

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE/DONE + `start`:
  - clear all accumulators, `vec_count`, worst registers and the `stim` counter to 0
  - go to SWEEP.
- SWEEP: each cycle, sample `exact_po`/`approx_po` for the current `stim` (partitions are combinational; same-cycle sampling), then:
  - `vec_count`++
  - `err_vectors`++ on any mismatch
  - `bit_errors` += popcount of the XOR
  - `abs_err_sum` += absolute difference
  - `stim`++
- SWEEP exit to DONE: on the cycle that accumulates `stim == 2^NI−1`. `stim` wraps to 0 on that edge and holds 0 in DONE.
- SWEEP + `abort`: go to IDLE. No accumulation on that cycle. Accumulators hold their partial values; `done` stays 0.
- `abort` and `start` asserted together in SWEEP: `abort` wins. `start` in SWEEP is ignored.
- Accumulator widths are sized so none can overflow in a full sweep; no saturation logic.
- Worst tracking: update only on strictly greater error, so ties keep the earliest vector.

## Timing
- Reset (async assert, sync deassert): state IDLE. Every output is 0: `stim`, `busy`, `done`, all counters and sums, `worst_err`, `worst_vec`.
- Start edge E0: `busy`=1 and `stim`=0 after E0.
- Edge Ek (k=1..2^NI) accumulates vector k−1.
- After E(2^NI): `busy`=0, `done`=1, `vec_count`=2^NI. Sweep latency is exactly 2^NI cycles after the start edge; 128 for NI=7.
- `done` is a level held until the next accepted `start` or reset. It drops on the start edge.
- Outputs are registered and change only on rising `clk`, except for async reset.
- Reset mid-sweep: immediate return to IDLE with all outputs 0.

## Configuration
- `SWEEP_WORST_CASE_EN` defined:
  - `worst_err`/`worst_vec` registers and the magnitude comparator are built, behaving as above.
- Not defined:
  - `worst_err` and `worst_vec` are tied to constant 0; the ports remain.
  - All other behaviour is identical.

## Test plan
- Identical partitions (`approx_po = exact_po`), NI=7, NO=4, pulse `start`:
  - `done` rises 128 cycles after the start edge
  - `vec_count`=128
  - `err_vectors`=`bit_errors`=`abs_err_sum`=0, `worst_err`=0, `worst_vec`=0.
- `exact_po = stim[3:0]`, `approx_po = stim[3:0] ^ 4'b0001`:
  - `err_vectors`=128, `bit_errors`=128, `abs_err_sum`=128
  - `worst_err`=1, `worst_vec`=0.
- `exact_po = stim[3:0]`, `approx_po = 0`:
  - `err_vectors`=120, `bit_errors`=256, `abs_err_sum`=960
  - `worst_err`=15, `worst_vec`=15; with the macro undefined both are 0.
- `abort` asserted when `stim`=50:
  - next cycle: IDLE, `busy`=0, `done`=0, `vec_count`=50
  - a new `start` then yields clean full-sweep results matching the scenario rerun.
- `start` held high throughout a sweep: ignored; a single sweep of 128 cycles. Holding it into DONE restarts on the first DONE cycle and `done` drops.
- `rst_n` pulsed low at `stim`=77: all outputs read 0 immediately (asynchronously). After release, state is IDLE until `start`.
